// File: rtl/dcm_if.sv
// Phase-shift handshake between the dmix control logic and the dcm block.
interface dcm_if;
    logic psen;
    logic psincdec;
    logic psdone;

    modport master (output psen, output psincdec, input psdone);
    modport slave  (input psen, input psincdec, output psdone);
endinterface

// File: rtl/dcm.sv
// Synthesizable clock manager: /2 and /4 divided clocks, a fractional CLKFX
// enable strobe, a sticky lock indicator and a one-step phase shifter.
module dcm #(
    parameter int unsigned CLKFX_MULTIPLY = 4,
    parameter int unsigned CLKFX_DIVIDE   = 1,
    parameter int unsigned LOCK_CYCLES    = 16
) (
    input  logic  clk983040,
    input  logic  rst_n,
    dcm_if.slave  ps,
    output logic  clk0,
    output logic  clk2x,
    output logic  clkfx_en,
    output logic  locked
);

    localparam int unsigned FX_MOD = 4 * CLKFX_DIVIDE;
    localparam int unsigned ACC_W  = $clog2(FX_MOD) + 1;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned LCK_W  = 16;

    typedef enum logic [1:0] {
        PS_IDLE  = 2'd0,
        PS_SHIFT = 2'd1,
        PS_DONE  = 2'd2
    } ps_state_t;

    ps_state_t          r_ps_state;
    ps_state_t          w_ps_state_nxt;
    logic [1:0]         r_cnt;
    logic [1:0]         w_cnt_nxt;
    logic [LCK_W-1:0]   r_lock_cnt;
    logic [LCK_W-1:0]   w_lock_cnt_nxt;
    logic               r_locked;
    logic               w_locked_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               r_fx_en;
    logic               w_fx_en_nxt;
    logic               r_ps_dir;
    logic               w_ps_dir_nxt;
    logic               r_psdone;
    logic               w_psdone_nxt;
    logic [SUM_W-1:0]   w_sum;

    // State register for every piece of sequential state in the block.
    always_ff @(posedge clk983040 or negedge rst_n) begin
        if (!rst_n) begin
            r_ps_state <= PS_IDLE;
            r_cnt      <= 2'd0;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
            r_acc      <= '0;
            r_fx_en    <= 1'b0;
            r_ps_dir   <= 1'b0;
            r_psdone   <= 1'b0;
        end else begin
            r_ps_state <= w_ps_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_locked   <= w_locked_nxt;
            r_acc      <= w_acc_nxt;
            r_fx_en    <= w_fx_en_nxt;
            r_ps_dir   <= w_ps_dir_nxt;
            r_psdone   <= w_psdone_nxt;
        end
    end

    // Next-state logic: divider, lock counter, DDS and phase-shift FSM.
    always_comb begin
        w_ps_state_nxt = r_ps_state;
        w_cnt_nxt      = r_cnt + 2'd1;
        w_lock_cnt_nxt = r_lock_cnt;
        w_acc_nxt      = '0;
        w_fx_en_nxt    = 1'b0;
        w_ps_dir_nxt   = r_ps_dir;
        w_psdone_nxt   = 1'b0;
        w_sum          = SUM_W'(r_acc) + SUM_W'(CLKFX_MULTIPLY);

        if (r_lock_cnt != LCK_W'(LOCK_CYCLES)) begin
            w_lock_cnt_nxt = r_lock_cnt + LCK_W'(1);
        end
        // Saturated counter keeps locked high until the next reset.
        w_locked_nxt = (w_lock_cnt_nxt == LCK_W'(LOCK_CYCLES));

        if (r_locked) begin
            if (w_sum >= SUM_W'(FX_MOD)) begin
                w_acc_nxt   = ACC_W'(w_sum - SUM_W'(FX_MOD));
                w_fx_en_nxt = 1'b1;
            end else begin
                w_acc_nxt   = ACC_W'(w_sum);
            end
        end

        case (r_ps_state)
            PS_IDLE: begin
                if (r_locked && ps.psen) begin
                    w_ps_state_nxt = PS_SHIFT;
                    w_ps_dir_nxt   = ps.psincdec;
                end
            end
            PS_SHIFT: begin
                // Retard holds the divider one cycle; advance skips a step.
                w_cnt_nxt      = r_ps_dir ? r_cnt : r_cnt + 2'd2;
                w_ps_state_nxt = PS_DONE;
            end
            PS_DONE: begin
                w_psdone_nxt   = 1'b1;
                w_ps_state_nxt = PS_IDLE;
            end
            default: begin
                w_ps_state_nxt = PS_IDLE;
            end
        endcase
    end

    assign clk2x     = r_cnt[0];
    assign clk0      = r_cnt[1];
    assign clkfx_en  = r_fx_en;
    assign locked    = r_locked;
    assign ps.psdone = r_psdone;

endmodule

// File: tb/tb_dcm.sv
// Self-checking bench for dcm: three parameterisations against a
// behavioural model driven by directed and random phase-shift traffic.
module tb_dcm;

    localparam int LOCK = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcm_if if_a ();
    dcm_if if_b ();
    dcm_if if_c ();

    logic clk0_a, clk2x_a, fx_a, lk_a;
    logic clk0_b, clk2x_b, fx_b, lk_b;
    logic clk0_c, clk2x_c, fx_c, lk_c;

    dcm #(.CLKFX_MULTIPLY(4), .CLKFX_DIVIDE(1), .LOCK_CYCLES(LOCK)) u_a (
        .clk983040(clk), .rst_n(rst_n), .ps(if_a),
        .clk0(clk0_a), .clk2x(clk2x_a), .clkfx_en(fx_a), .locked(lk_a));
    dcm #(.CLKFX_MULTIPLY(3), .CLKFX_DIVIDE(1), .LOCK_CYCLES(LOCK)) u_b (
        .clk983040(clk), .rst_n(rst_n), .ps(if_b),
        .clk0(clk0_b), .clk2x(clk2x_b), .clkfx_en(fx_b), .locked(lk_b));
    dcm #(.CLKFX_MULTIPLY(1), .CLKFX_DIVIDE(4), .LOCK_CYCLES(LOCK)) u_c (
        .clk983040(clk), .rst_n(rst_n), .ps(if_c),
        .clk0(clk0_c), .clk2x(clk2x_c), .clkfx_en(fx_c), .locked(lk_c));

    // Reference model: edges since release, divider phase, pending shift.
    int t, m_cnt, acc_t;
    bit pend, pdir, m_done;
    int n_checks = 0;
    int n_fail   = 0;

    // Strobes of an ideal M/(4D) rate counted from lock: difference of floors.
    function automatic int fx_exp(input int m, input int d, input int tt);
        int k;
        k = tt - LOCK;
        if (k < 1) return 0;
        return (k * m) / (4 * d) - ((k - 1) * m) / (4 * d);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp_v, t);
        end
    endtask

    task automatic check_all();
        chk("clk2x_a",  int'(clk2x_a),     m_cnt % 2);
        chk("clk0_a",   int'(clk0_a),      m_cnt / 2);
        chk("locked_a", int'(lk_a),        int'(t >= LOCK));
        chk("psdone_a", int'(if_a.psdone), int'(m_done));
        chk("fx_a",     int'(fx_a),        fx_exp(4, 1, t));
        chk("locked_b", int'(lk_b),        int'(t >= LOCK));
        chk("fx_b",     int'(fx_b),        fx_exp(3, 1, t));
        chk("fx_c",     int'(fx_c),        fx_exp(1, 4, t));
        chk("clk0_c",   int'(clk0_c),      int'(pend) * 0 + ((t % 4) / 2));
        chk("psdone_b", int'(if_b.psdone), 0);
    endtask

    task automatic step(input bit p, input bit d);
        bit accept;
        if_a.psen     = p;
        if_a.psincdec = d;
        @(posedge clk);
        #1;
        t++;
        accept = p && (t - 1 >= LOCK) && !pend;
        m_done = 1'b0;
        if (pend && t == acc_t + 1)
            m_cnt = (m_cnt + (pdir ? 0 : 2)) % 4;
        else
            m_cnt = (m_cnt + 1) % 4;
        if (pend && t == acc_t + 2) begin
            m_done = 1'b1;
            pend   = 1'b0;
        end
        if (accept) begin
            pend  = 1'b1;
            acc_t = t;
            pdir  = d;
        end
        check_all();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        if_a.psen = 1'b0;
        rst_n     = 1'b0;
        #1;
        t = 0; m_cnt = 0; pend = 1'b0; m_done = 1'b0;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int nd, nstb;
        if_a.psen = 1'b0; if_a.psincdec = 1'b0;
        if_b.psen = 1'b0; if_b.psincdec = 1'b0;
        if_c.psen = 1'b0; if_c.psincdec = 1'b0;
        #1;

        // Release, divider sequence and lock at edge 16.
        do_reset();
        repeat (20) step(1'b0, 1'b0);

        // Single retard then single advance.
        step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);

        // psen held for 5 cycles: two accepted shifts.
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            step(i < 5, 1'b1);
            nd += int'(if_a.psdone);
        end
        chk("psdone_held_count", nd, 2);

        // Requests before lock are ignored.
        do_reset();
        nd = 0;
        repeat (15) begin
            step(1'b1, 1'b0);
            nd += int'(if_a.psdone);
        end
        chk("psdone_prelock_count", nd, 0);
        repeat (10) step(1'b0, 1'b0);

        // Reset in the middle of a shift, then in the middle of lock counting.
        step(1'b1, 1'b1);
        do_reset();
        repeat (7) step(1'b0, 1'b0);
        do_reset();
        repeat (LOCK) step(1'b0, 1'b0);

        // M=1, D=4: 64 strobes in 1024 cycles after lock.
        nstb = 0;
        repeat (1024) begin
            step(1'b0, 1'b0);
            nstb += int'(fx_c);
        end
        chk("fx_c_1024_count", nstb, 64);

        // Random phase-shift traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(199) == 0) do_reset();
            step($urandom_range(3) == 0, 1'($urandom_range(1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
